// File: rtl/mbm_mac.sv
// Pipelined signed 8x8 multiply-accumulate: S1 operand regs, MBM Booth multiplier
// into S2 product regs, S3 saturating accumulator with a valid/ready output.

module MBM #(
  parameter int w = 8
) (
  input  logic [w-1:0]   a,
  input  logic [w-1:0]   b,
  output logic [2*w-1:0] p
);
  logic [w:0]     bx;
  logic [2*w-1:0] ae;

  // Radix-4 Booth: overlapping triplets of b, with an implicit zero below the LSB.
  assign bx = {b, 1'b0};
  assign ae = {{w{a[w-1]}}, a};

  always_comb begin
    logic [2:0]     trip;
    logic [2*w-1:0] pp;
    p    = '0;
    trip = '0;
    pp   = '0;
    for (int i = 0; i < w / 2; i++) begin
      trip = bx[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = ae;
        3'b011:         pp = ae << 1;
        3'b100:         pp = -(ae << 1);
        3'b101, 3'b110: pp = -ae;
        default:        pp = '0;
      endcase
      p = p + (pp << (2 * i));
    end
  end
endmodule

module mbm_mac #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MAC = 2'b01;
  localparam logic [1:0] OP_MSU = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Handshake: a transfer happens on an edge where valid & ready are both high.
  // The whole pipeline freezes while a result is offered but not taken, so
  // in_ready depends only on out_valid/out_ready and never on in_valid.
  logic stall;
  logic adv;

  logic       s1_v;
  logic [1:0] s1_op;
  logic [7:0] s1_a;
  logic [7:0] s1_b;

  logic        s2_v;
  logic [1:0]  s2_op;
  logic [15:0] s2_p;

  logic [15:0]      prod;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;
  logic [ACC_W-1:0] pe;
  logic [ACC_W:0]   sum;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;
  assign result   = acc;

  MBM #(.w(8)) u_mbm (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

  assign pe = {{(ACC_W-16){s2_p[15]}}, s2_p};

  always_comb begin
    acc_nxt = acc;
    ovf_nxt = ovf;
    sum     = '0;
    case (s2_op)
      OP_MUL: begin
        acc_nxt = pe;
        ovf_nxt = 1'b0;
      end
      OP_MAC, OP_MSU: begin
        // One guard bit: sign disagreement between the top two bits means overflow.
        if (s2_op == OP_MAC) sum = {acc[ACC_W-1], acc} + {pe[ACC_W-1], pe};
        else                 sum = {acc[ACC_W-1], acc} - {pe[ACC_W-1], pe};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
          acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
          ovf_nxt = 1'b1;
        end else begin
          acc_nxt = sum[ACC_W-1:0];
        end
      end
      OP_CLR: begin
        acc_nxt = '0;
        ovf_nxt = 1'b0;
      end
      default: begin
        acc_nxt = acc;
        ovf_nxt = ovf;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_op <= '0;
      s1_a  <= '0;
      s1_b  <= '0;
    end else if (adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_op <= op;
        s1_a  <= a;
        s1_b  <= b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v  <= 1'b0;
      s2_op <= '0;
      s2_p  <= '0;
    end else if (adv) begin
      s2_v  <= s1_v;
      s2_op <= s1_op;
      s2_p  <= prod;
    end
  end

  // Bubbles advance out_valid low but leave acc/ovf untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_v;
      if (s2_v) begin
        acc <= acc_nxt;
        ovf <= ovf_nxt;
      end
    end
  end
endmodule

// File: tb/tb_mbm_mac.sv
// Bench for mbm_mac: directed vector table, saturation/stall/reset sequences and
// a random stream, all checked through an in-order expected-result queue.

module tb_mbm_mac;
  localparam int ACC_W = 20;
  localparam int W     = ACC_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             ovf;

  int errors = 0;
  int checks = 0;
  int outs   = 0;
  logic [W-1:0] exp_q[$];
  longint m_acc = 0;
  logic   m_ovf = 1'b0;
  logic   rnd_done;

  typedef struct {
    logic [1:0]       op;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [ACC_W-1:0] res;
    logic             ovf;
  } vec_t;
  vec_t vecs[12];

  mbm_mac #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference saturating accumulator
  function automatic logic [W-1:0] model_step(input logic [1:0] o, input logic [7:0] x,
                                               input logic [7:0] y);
    longint prod;
    longint maxv;
    longint minv;
    prod = longint'($signed(x)) * longint'($signed(y));
    maxv = (longint'(1) <<< (ACC_W - 1)) - 1;
    minv = -(longint'(1) <<< (ACC_W - 1));
    case (o)
      2'b00: begin m_acc = prod; m_ovf = 1'b0; end
      2'b01: m_acc = m_acc + prod;
      2'b10: m_acc = m_acc - prod;
      default: begin m_acc = 0; m_ovf = 1'b0; end
    endcase
    if (m_acc > maxv) begin
      m_acc = maxv;
      m_ovf = 1'b1;
    end else if (m_acc < minv) begin
      m_acc = minv;
      m_ovf = 1'b1;
    end
    return {m_ovf, m_acc[ACC_W-1:0]};
  endfunction

  // Driver: called at posedge+1, returns at posedge+1 after acceptance
  task automatic send(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", {20'd0, in_ready}, 21'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_q.push_back(model_step(o, x, y));
    send(o, x, y);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", W'(exp_q.size()), '0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: a transfer seen at negedge completes on the next posedge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [W-1:0] e;
      outs++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h required no output", {ovf, result});
      end else begin
        e = exp_q.pop_front();
        check("sb_ovf_result", {ovf, result}, e);
      end
    end
  end

  initial begin
    int o0;
    logic [1:0] ro;

    vecs[0]  = '{2'b00, 8'd7,   8'hFD, 20'hFFFEB, 1'b0};
    vecs[1]  = '{2'b00, 8'h80,  8'h80, 20'h04000, 1'b0};
    vecs[2]  = '{2'b00, 8'd10,  8'd10, 20'h00064, 1'b0};
    vecs[3]  = '{2'b10, 8'h80,  8'd127, 20'h03FE4, 1'b0};
    vecs[4]  = '{2'b11, 8'd5,   8'd5,  20'h00000, 1'b0};
    vecs[5]  = '{2'b01, 8'd2,   8'd3,  20'h00006, 1'b0};
    vecs[6]  = '{2'b01, 8'hFB,  8'd4,  20'hFFFF2, 1'b0};
    vecs[7]  = '{2'b10, 8'd3,   8'hF9, 20'h00007, 1'b0};
    vecs[8]  = '{2'b01, 8'h80,  8'd127, 20'hFC087, 1'b0};
    vecs[9]  = '{2'b00, 8'd127, 8'd127, 20'h03F01, 1'b0};
    vecs[10] = '{2'b00, 8'hFF,  8'hFF, 20'h00001, 1'b0};
    vecs[11] = '{2'b00, 8'd0,   8'h80, 20'h00000, 1'b0};

    // Reset
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = '0;
    a         = '0;
    b         = '0;
    rnd_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {20'd0, out_valid}, 21'd0);
    check("reset_result", {1'b0, result}, '0);
    check("reset_ovf", {20'd0, ovf}, 21'd0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", {20'd0, in_ready}, 21'd1);
    idle(1);

    // Latency: result visible after the second edge past acceptance
    exp_q.push_back(model_step(2'b00, 8'd7, 8'hFD));
    send(2'b00, 8'd7, 8'hFD);
    @(negedge clk);
    check("lat_s1_no_out", {20'd0, out_valid}, 21'd0);
    @(negedge clk);
    check("lat_s2_no_out", {20'd0, out_valid}, 21'd0);
    @(negedge clk);
    check("lat_s3_out", {20'd0, out_valid}, 21'd1);
    check("lat_s3_result", {ovf, result}, {1'b0, 20'hFFFEB});
    drain();

    // Directed vector table, issued back to back
    for (int i = 0; i < 12; i++) begin
      void'(model_step(vecs[i].op, vecs[i].a, vecs[i].b));
      exp_q.push_back({vecs[i].ovf, vecs[i].res});
      send(vecs[i].op, vecs[i].a, vecs[i].b);
    end
    drain();

    // Saturation: CLR then 33 x MAC 127*127, then MSU 1*1
    issue(2'b11, 8'd0, 8'd0);
    for (int i = 0; i < 33; i++) issue(2'b01, 8'd127, 8'd127);
    issue(2'b10, 8'd1, 8'd1);
    drain();
    check("sat_msu_result", {1'b0, result}, {1'b0, 20'h7FFFE});
    check("sat_msu_ovf", {20'd0, ovf}, 21'd1);

    // Asynchronous reset with requests in flight
    issue(2'b01, 8'd5, 8'd5);
    issue(2'b01, 8'd6, 8'd6);
    issue(2'b01, 8'd7, 8'd7);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {20'd0, out_valid}, 21'd0);
    check("arst_result", {1'b0, result}, '0);
    check("arst_ovf", {20'd0, ovf}, 21'd0);
    exp_q.delete();
    m_acc = 0;
    m_ovf = 1'b0;
    o0 = outs;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
    check("arst_no_outputs", W'(outs - o0), '0);
    issue(2'b01, 8'd2, 8'd3);
    drain();
    check("arst_mac_after", {1'b0, result}, 21'd6);

    // Stall: out_ready low for 4 cycles when the first MAC result appears
    o0 = outs;
    fork
      begin
        issue(2'b11, 8'd0, 8'd0);
        issue(2'b01, 8'd1, 8'd1);
        issue(2'b01, 8'd2, 8'd2);
        issue(2'b01, 8'd3, 8'd3);
      end
      begin
        int n = 0;
        while (!(out_valid && result == 20'd1) && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("stall_first_seen", {20'd0, out_valid}, 21'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("stall_in_ready", {20'd0, in_ready}, 21'd0);
          check("stall_hold", {out_valid, result}, {1'b1, 20'd1});
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_out_count", W'(outs - o0), 21'd4);
    check("stall_final", {ovf, result}, {1'b0, 20'd14});

    // Random stream with random backpressure
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          case ($urandom_range(0, 9))
            0:             ro = 2'b00;
            1:             ro = 2'b11;
            2, 3, 4, 5, 6: ro = 2'b01;
            default:       ro = 2'b10;
          endcase
          if ($urandom_range(0, 1) == 0)
            issue(ro, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
          else
            issue(ro, 8'($urandom_range(100, 127)), 8'($urandom_range(100, 127)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("final_queue_empty", W'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
